// File: rtl/blk_b639ac_if.sv
// Register file access bundle: two read ports, one write port.
// Master drives addresses and write data, slave returns read data.
interface blk_b639ac_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Rna;
    logic [ADDR_W-1:0] Rnb;
    logic [ADDR_W-1:0] Wn;
    logic              a1;
    logic [DATA_W-1:0] Wd;
    logic [DATA_W-1:0] Qa;
    logic [DATA_W-1:0] Qb;

    modport master (
        output Rna, Rnb, Wn, a1, Wd,
        input  Qa, Qb
    );

    modport slave (
        input  Rna, Rnb, Wn, a1, Wd,
        output Qa, Qb
    );
endinterface

// File: rtl/blk_b639ac.sv
// MIPS-style register file, 2 combinational reads, 1 clocked write.
// Register 0 has no storage and always reads as zero.
module blk_b639ac #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic          clk,
    input logic          Reset,
    blk_b639ac_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic              we;

    // Only a clean 1 on a1 writes; register 0 writes are dropped.
    always_comb begin
        we = 1'b0;
        if ((bus.a1 == 1'b1) && (bus.Wn != '0))
            we = 1'b1;
    end

    // Storage: async clear on Reset low, else load on write.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[bus.Wn] <= bus.Wd;
        end
    end

    // Combinational reads, no bypass from the write port.
    always_comb begin
        bus.Qa = '0;
        bus.Qb = '0;
        if (bus.Rna != '0)
            bus.Qa = regs[bus.Rna];
        if (bus.Rnb != '0)
            bus.Qb = regs[bus.Rnb];
    end
endmodule

// File: tb/tb_blk_b639ac.sv
// Self-checking bench for blk_b639ac.
// Directed steps followed by random traffic against an array model.
`timescale 1ns/100ps
module tb_blk_b639ac;
    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic Reset;

    int vectors = 0;
    int errs = 0;
    logic [31:0] model [0:31];

    blk_b639ac_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    blk_b639ac #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Spec rule: a write lands only out of reset, with a1=1 and Wn!=0.
    task automatic model_edge(input logic we, input logic [4:0] wn,
                              input logic [31:0] wd);
        if (Reset === 1'b1 && we === 1'b1 && wn != 5'd0)
            model[wn] = wd;
    endtask

    task automatic rd(input string tag, input logic [4:0] ra,
                      input logic [4:0] rb);
        bus.Rna = ra;
        bus.Rnb = rb;
        #1;
        chk({tag, "_qa"}, bus.Qa, model[ra]);
        chk({tag, "_qb"}, bus.Qb, model[rb]);
    endtask

    // Apply a write request and clock it; returns just after negedge.
    task automatic wr(input logic we, input logic [4:0] wn,
                      input logic [31:0] wd);
        bus.a1 = we;
        bus.Wn = wn;
        bus.Wd = wd;
        @(posedge clk);
        model_edge(we, wn, wd);
        @(negedge clk);
        bus.a1 = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra, rb, wn;
        logic        we;
        logic [31:0] wd;

        clear_model();
        Reset = 1'b0;
        bus.a1 = 1'b0;
        bus.Rna = 5'd1;
        bus.Rnb = 5'd2;
        bus.Wn = 5'd0;
        bus.Wd = 32'h0;

        // Reset held: everything reads zero.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) rd("rst_sweep", 5'(i), 5'(31 - i));

        // Release, alternate a1 with Wn=0.
        Reset = 1'b1;
        bus.Rna = 5'd1;
        bus.Rnb = 5'd2;
        for (int i = 0; i < 4; i++) begin
            wr(1'(i % 2 == 0), 5'd0, 32'h0);
            rd("rel_r0", 5'd1, 5'd2);
        end

        // Basic writes.
        wr(1'b1, 5'd1, 32'hDEADBEEF);
        wr(1'b1, 5'd2, 32'h12345678);
        rd("wr12", 5'd1, 5'd2);
        chk("wr1_abs", bus.Qa, 32'hDEADBEEF);
        chk("wr2_abs", bus.Qb, 32'h12345678);

        // Write to register 0 discarded.
        wr(1'b1, 5'd0, 32'hFFFFFFFF);
        rd("r0_wr", 5'd0, 5'd0);
        chk("r0_abs", bus.Qa, 32'h0);

        // a1=0 blocks the write.
        wr(1'b0, 5'd3, 32'hAAAA5555);
        rd("no_we", 5'd3, 5'd3);
        chk("no_we_abs", bus.Qa, 32'h0);

        // Read during write: old before edge, new after.
        wr(1'b1, 5'd5, 32'h11);
        bus.Rna = 5'd5;
        bus.Rnb = 5'd5;
        bus.a1 = 1'b1;
        bus.Wn = 5'd5;
        bus.Wd = 32'h22;
        #1;
        chk("rdw_old", bus.Qa, 32'h11);
        @(posedge clk);
        model_edge(1'b1, 5'd5, 32'h22);
        #1;
        chk("rdw_new_a", bus.Qa, 32'h22);
        chk("rdw_new_b", bus.Qb, 32'h22);
        @(negedge clk);
        bus.a1 = 1'b0;

        // Random traffic, reads checked on both sides of each edge.
        for (int n = 0; n < 300; n++) begin
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 7) == 0) ? ra : 5'($urandom_range(0, 31));
            wn = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            bus.a1 = we;
            bus.Wn = wn;
            bus.Wd = wd;
            rd("rnd_pre", ra, rb);
            @(posedge clk);
            model_edge(we, wn, wd);
            #1;
            chk("rnd_post_a", bus.Qa, model[ra]);
            chk("rnd_post_b", bus.Qb, model[rb]);
            @(negedge clk);
        end
        bus.a1 = 1'b0;

        // Reset priority over a write on the same edge.
        wr(1'b1, 5'd9, 32'h99);
        Reset = 1'b0;
        clear_model();
        bus.a1 = 1'b1;
        bus.Wn = 5'd9;
        bus.Wd = 32'h77;
        @(posedge clk);
        #1;
        rd("rst_prio", 5'd9, 5'd9);
        @(negedge clk);
        bus.a1 = 1'b0;
        Reset = 1'b1;

        // Fill 1..31, then async reset with the clock stopped.
        for (int i = 1; i < 32; i++)
            wr(1'b1, 5'(i), 32'hC0DE0000 + 32'(i * 17));
        rd("fill_chk", 5'd31, 5'd17);
        clk_en = 1'b0;
        #3;
        Reset = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) rd("async_clr", 5'(i), 5'(31 - i));
        Reset = 1'b1;
        #1;
        rd("after_rel", 5'd4, 5'd30);
        clk_en = 1'b1;
        @(negedge clk);

        // First write after release lands on the next edge.
        bus.Rna = 5'd7;
        bus.Rnb = 5'd0;
        wr(1'b1, 5'd7, 32'h0BADF00D);
        rd("first_wr", 5'd7, 5'd0);
        chk("first_wr_abs", bus.Qa, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/blk_b639ac.md
REG -- requirements
Module: Reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register and data-port width.
REQ-002 Parameter ADDR_W, default 5, SHALL set register-number width; depth = 2**ADDR_W (32 registers).
REQ-003 Port clk  input  1  SHALL be the single clock; writes occur on its rising edge.
REQ-004 Port Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port Rna  input  ADDR_W  SHALL select the register for read port A.
REQ-006 Port Rnb  input  ADDR_W  SHALL select the register for read port B.
REQ-007 Port Wn  input  ADDR_W  SHALL select the register to write.
REQ-008 Port a1  input  1  SHALL be the active-high write enable.
REQ-009 Port Wd  input  DATA_W  SHALL carry the write data.
REQ-010 Port Qa  output  DATA_W  SHALL return the contents of register Rna.
REQ-011 Port Qb  output  DATA_W  SHALL return the contents of register Rnb.
REQ-012 The clock SHALL be clk and the reset SHALL be Reset, asynchronous and active-low; the block SHALL use no other clock or reset.

Function
REQ-013 The block SHALL be a MIPS-style register file with 2 read ports and 1 write port.
REQ-014 Register 0 SHALL be hardwired to zero: reads of register 0 SHALL return 0, and writes to register 0 SHALL be discarded.
REQ-015 Reads SHALL be combinational: Qa and Qb SHALL follow changes on Rna and Rnb, and on register contents, with no clock latency.
REQ-016 On a clk rising edge with Reset=1, a1=1 and Wn!=0, register Wn SHALL load Wd.
REQ-017 With a1=0, no register SHALL change on the clock edge.
REQ-018 Read-during-write to the same register SHALL return the old value before the edge and the new value after it; there SHALL be no write-to-read bypass.
REQ-019 Both read ports SHALL be independent: Rna=Rnb SHALL give identical Qa and Qb.
REQ-020 X or Z values on a1 SHALL NOT be treated as a write.

Reset
REQ-021 While Reset=0, all registers SHALL be cleared to 0 immediately, regardless of clk; Qa and Qb SHALL read 0 for every address.
REQ-022 Reset SHALL take priority over writes: an edge with a1=1 while Reset=0 SHALL NOT write.
REQ-023 Reset asserted in the middle of operation SHALL clear all previously written data.
REQ-024 After Reset returns to 1, the first write SHALL take effect on the next rising clk edge.

Verification
REQ-025 Hold Reset=0 with a1=0 and Rna=1, Rnb=2, then release Reset to 1 and toggle clk with a1 alternating 1/0, Wn=0, Wd=0 -> Qa=0 and Qb=0 throughout.
REQ-026 Write Wn=1, Wd=0xDEADBEEF, then Wn=2, Wd=0x12345678, then read Rna=1, Rnb=2 -> Qa=0xDEADBEEF, Qb=0x12345678.
REQ-027 Write Wn=0, Wd=0xFFFFFFFF with a1=1, then read Rna=0 -> Qa=0.
REQ-028 With a1=0, present Wn=3, Wd=0xAAAA5555 and clock -> register 3 still reads 0.
REQ-029 With register 5=0x11 and Rna=5, present Wn=5, Wd=0x22 with a1=1 -> Qa=0x11 before the edge and 0x22 after it.
REQ-030 Fill registers 1-31 with distinct values, then pulse Reset=0 between clk edges -> every register reads 0 immediately, with no clock edge required.
